// File: rtl/execute_pkg.sv
// Shared encodings for the EX stage: main-control ALU op classes, R-type funct
// codes and the internal 3-bit ALU control word.
package execute_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam int         ALUOP_RTYPE = 1;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_INV = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    // Unknown R-type funct maps to ALU_INV, which the ALU turns into a zero result.
    function automatic alu_ctl_e alu_ctl_decode(input logic [1:0] aluop,
                                                input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_INV;
        if (aluop[ALUOP_RTYPE]) begin
            case (funct)
                FUNCT_ADD: ctl = ALU_ADD;
                FUNCT_SUB: ctl = ALU_SUB;
                FUNCT_AND: ctl = ALU_AND;
                FUNCT_OR:  ctl = ALU_OR;
                FUNCT_SLT: ctl = ALU_SLT;
                default:   ctl = ALU_INV;
            endcase
        end else if (aluop == ALUOP_SUB) begin
            ctl = ALU_SUB;
        end else begin
            ctl = ALU_ADD;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// 32-bit combinational ALU: add, sub, and, or, signed set-less-than.
module execute_alu
    import execute_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctl,
    output logic [31:0] result,
    output logic        zero
);

    logic [31:0] w_result;

    always_comb begin
        w_result = 32'h0;
        case (ctl)
            ALU_ADD: w_result = a + b;
            ALU_SUB: w_result = a - b;
            ALU_AND: w_result = a & b;
            ALU_OR:  w_result = a | b;
            ALU_SLT: w_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: w_result = 32'h0;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == 32'h0);

endmodule

// File: rtl/execute.sv
// MIPS EX stage: ALU control decode, operand/destination muxes, branch target
// adder and the EX/MEM pipeline register.
module execute
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic        regdst,
    input  logic        alusrc,
    input  logic [1:0]  aluop,
    input  logic [31:0] npcout,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] s_extendout,
    input  logic [4:0]  instrout_2016,
    input  logic [4:0]  instrout_1511,
    input  logic [5:0]  funct,
    output logic [1:0]  wb_ctlout,
    output logic        branch,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] EX_MEM_NPC,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2out,
    output logic [4:0]  five_bit_muxout
);

    alu_ctl_e    w_alu_ctl;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;
    logic [31:0] w_target;
    logic [4:0]  w_dest;

    assign w_alu_ctl = alu_ctl_decode(aluop, funct);
    assign w_alu_b   = alusrc ? s_extendout : rdata2;
    assign w_dest    = regdst ? instrout_1511 : instrout_2016;
    // Target is computed unconditionally; MEM decides whether to take it.
    assign w_target  = npcout + (s_extendout << 2);

    execute_alu u_alu (
        .a      (rdata1),
        .b      (w_alu_b),
        .ctl    (w_alu_ctl),
        .result (w_alu_result),
        .zero   (w_alu_zero)
    );

    logic [1:0]  r_wb_ctl;
    logic [2:0]  r_m_ctl;
    logic [31:0] r_npc;
    logic        r_zero;
    logic [31:0] r_alu_result;
    logic [31:0] r_rdata2;
    logic [4:0]  r_dest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_ctl     <= 2'b0;
            r_m_ctl      <= 3'b0;
            r_npc        <= 32'h0;
            r_zero       <= 1'b0;
            r_alu_result <= 32'h0;
            r_rdata2     <= 32'h0;
            r_dest       <= 5'h0;
        end else begin
            r_wb_ctl     <= wb_ctl;
            r_m_ctl      <= m_ctl;
            r_npc        <= w_target;
            r_zero       <= w_alu_zero;
            r_alu_result <= w_alu_result;
            r_rdata2     <= rdata2;
            r_dest       <= w_dest;
        end
    end

    assign wb_ctlout       = r_wb_ctl;
    assign branch          = r_m_ctl[2];
    assign memread         = r_m_ctl[1];
    assign memwrite        = r_m_ctl[0];
    assign EX_MEM_NPC      = r_npc;
    assign zero            = r_zero;
    assign alu_result      = r_alu_result;
    assign rdata2out       = r_rdata2;
    assign five_bit_muxout = r_dest;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the EX stage: directed cases plus random vectors
// against an arithmetic reference model.
module tb_execute;

    logic        clk;
    logic        clk_en;
    logic        reset;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npcout;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] s_extendout;
    logic [4:0]  instrout_2016;
    logic [4:0]  instrout_1511;
    logic [5:0]  funct;
    logic [1:0]  wb_ctlout;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] EX_MEM_NPC;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  five_bit_muxout;

    int n_checks;
    int n_pass;

    execute dut (
        .clk             (clk),
        .reset           (reset),
        .wb_ctl          (wb_ctl),
        .m_ctl           (m_ctl),
        .regdst          (regdst),
        .alusrc          (alusrc),
        .aluop           (aluop),
        .npcout          (npcout),
        .rdata1          (rdata1),
        .rdata2          (rdata2),
        .s_extendout     (s_extendout),
        .instrout_2016   (instrout_2016),
        .instrout_1511   (instrout_1511),
        .funct           (funct),
        .wb_ctlout       (wb_ctlout),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .EX_MEM_NPC      (EX_MEM_NPC),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: result of the ALU from the instruction semantics.
    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] fn,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        case (fn)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_all"}, {wb_ctlout, branch, memread, memwrite, zero, five_bit_muxout,
                   EX_MEM_NPC[15:0]} | alu_result | rdata2out | {16'h0, EX_MEM_NPC[31:16]}, 32'h0);
    endtask

    // Drive current inputs, clock once, compare all outputs to the model.
    task automatic step_and_check(input string tag);
        logic [31:0] b, exp_res, exp_npc;
        b       = alusrc ? s_extendout : rdata2;
        exp_res = model_alu(aluop, funct, rdata1, b);
        exp_npc = npcout + s_extendout * 4;
        @(posedge clk);
        #1;
        $display("txn %s aluop=%b funct=%h a=%h b=%h res=%h npc=%h", tag, aluop, funct,
                 rdata1, b, alu_result, EX_MEM_NPC);
        check_val({tag, "_res"},  alu_result, exp_res);
        check_val({tag, "_zero"}, {31'h0, zero}, {31'h0, exp_res == 0});
        check_val({tag, "_npc"},  EX_MEM_NPC, exp_npc);
        check_val({tag, "_dest"}, {27'h0, five_bit_muxout},
                  {27'h0, regdst ? instrout_1511 : instrout_2016});
        check_val({tag, "_wb"},   {30'h0, wb_ctlout}, {30'h0, wb_ctl});
        check_val({tag, "_m"},    {29'h0, branch, memread, memwrite}, {29'h0, m_ctl});
        check_val({tag, "_rd2"},  rdata2out, rdata2);
    endtask

    initial begin
        logic [5:0] fn_tab [6];
        fn_tab[0] = 6'd32; fn_tab[1] = 6'd34; fn_tab[2] = 6'd36;
        fn_tab[3] = 6'd37; fn_tab[4] = 6'd42; fn_tab[5] = 6'd0;
        n_checks = 0;
        n_pass   = 0;
        clk_en   = 1'b0;
        reset    = 1'b0;
        wb_ctl = 2'b10; m_ctl = 3'b001; regdst = 1'b1; alusrc = 1'b1; aluop = 2'b10;
        npcout = 32'd100; rdata1 = 32'd10; rdata2 = 32'd20; s_extendout = 32'd4;
        instrout_2016 = 5'd5; instrout_1511 = 5'd10; funct = 6'b100000;

        #20;
        check_zero_outputs("rst_noclk");
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst_clk");
        @(negedge clk);
        reset = 1'b1;

        step_and_check("add_imm");
        check_val("add_imm_lit", alu_result, 32'd14);
        check_val("add_imm_npc_lit", EX_MEM_NPC, 32'd116);

        alusrc = 1'b0; regdst = 1'b0; s_extendout = 32'd8; aluop = 2'b01;
        step_and_check("sub_neg");
        check_val("sub_neg_lit", alu_result, 32'hFFFFFFF6);
        check_val("sub_neg_npc_lit", EX_MEM_NPC, 32'd132);

        rdata1 = 32'd20; rdata2 = 32'd20;
        step_and_check("sub_zero");
        check_val("sub_zero_lit", {31'h0, zero}, 32'd1);

        aluop = 2'b10; rdata1 = 32'hFFFFFFFF; rdata2 = 32'd1; funct = 6'b101010;
        step_and_check("slt");
        check_val("slt_lit", alu_result, 32'd1);
        rdata1 = 32'hF0F0; rdata2 = 32'hFF00; funct = 6'b100100;
        step_and_check("and");
        check_val("and_lit", alu_result, 32'hF000);
        funct = 6'b100101;
        step_and_check("or");
        check_val("or_lit", alu_result, 32'hFFF0);
        funct = 6'b000000;
        step_and_check("badfn");

        npcout = 32'hFFFFFFFC; s_extendout = 32'h1;
        step_and_check("wrap_hi");
        check_val("wrap_hi_lit", EX_MEM_NPC, 32'h0);
        npcout = 32'd100; s_extendout = 32'hFFFFFFFF;
        step_and_check("wrap_neg");
        check_val("wrap_neg_lit", EX_MEM_NPC, 32'd96);

        for (int i = 0; i < 150; i++) begin
            wb_ctl        = 2'($urandom);
            m_ctl         = 3'($urandom);
            regdst        = 1'($urandom);
            alusrc        = 1'($urandom);
            aluop         = 2'($urandom);
            npcout        = $urandom;
            rdata1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rdata2        = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom;
            s_extendout   = {{16{1'($urandom)}}, 16'($urandom)};
            instrout_2016 = 5'($urandom);
            instrout_1511 = 5'($urandom);
            funct         = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
            step_and_check($sformatf("rnd%0d", i));
        end

        // Asynchronous reset between edges clears the register immediately.
        #2;
        reset = 1'b0;
        #1;
        check_zero_outputs("rst_async");
        @(posedge clk);
        #1;
        check_zero_outputs("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        step_and_check("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

EX stage of the 5-stage MIPS pipeline, between the ID/EX latch and the MEM stage. It decodes the ALU operation, selects the ALU B operand and the destination register, and computes the branch target. All results and the forwarded WB/M control bits are captured in the EX/MEM pipeline register.

## Interface
- No parameters; data width fixed at 32 bits, register index 5 bits.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears the EX/MEM register.
- wb_ctl  in  2  WB control bits, passed through.
- m_ctl  in  3  M control bits {branch, memread, memwrite}.
- regdst  in  1  1 = destination is instrout_1511 (rd); 0 = instrout_2016 (rt).
- alusrc  in  1  1 = ALU B operand is s_extendout; 0 = rdata2.
- aluop  in  2  ALU operation class from main control.
- npcout  in  32  PC+4 of the instruction.
- rdata1, rdata2  in  32  register file read data.
- s_extendout  in  32  sign-extended immediate.
- instrout_2016, instrout_1511  in  5  rt and rd fields.
- funct  in  6  instruction funct field.
- wb_ctlout  out  2  registered wb_ctl.
- branch, memread, memwrite  out  1  registered m_ctl[2], m_ctl[1], m_ctl[0].
- EX_MEM_NPC  out  32  registered branch target.
- zero  out  1  registered (ALU result == 0).
- alu_result  out  32  registered ALU result.
- rdata2out  out  32  registered rdata2 (store data).
- five_bit_muxout  out  5  registered destination register index.

## Operation
- ALU control decode:
  - aluop 00 → ADD.
  - aluop 01 → SUB.
  - aluop 1x → decode funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Any other funct → result 32'h0.
- Operands: A = rdata1; B = alusrc ? s_extendout : rdata2.
- ADD and SUB wrap modulo 2^32; no overflow flag.
- SLT is a signed compare: result is 32'd1 if A < B as two's complement, else 32'd0.
- zero = (ALU result == 32'h0), computed before registering.
- Branch target = npcout + (s_extendout << 2), modulo 2^32, independent of branch.
- Destination: regdst ? instrout_1511 : instrout_2016.
- rdata2out always carries rdata2, regardless of alusrc.
- All combinational paths are purely functional of current inputs; no internal state other than the EX/MEM register.

## Timing
- Every output is a flop updated on rising clk; latency is 1 cycle from inputs to outputs.
- No stall or flush inputs; the register loads every cycle.
- Reset low asynchronously forces all outputs to 0 immediately and holds them while low.
- First capture occurs on the first rising edge after reset goes high.
- Reset asserted mid-stream discards the in-flight result; no partial update.

## Structure
- Shared package holds:
  - aluop codes (00/01/1x);
  - funct constants (ADD, SUB, AND, OR, SLT);
  - internal ALU control encoding (010 add, 110 sub, 000 and, 001 or, 111 slt, others invalid → 0).
- One natural sub-module: alu (inputs a, b, 3-bit control; outputs result, zero).
- ALU control decode, both muxes, the target adder and the EX/MEM register live in execute.

## Test plan
- Reset low → all outputs 0, with and without clk activity; release → first edge captures inputs.
- wb_ctl=10, m_ctl=001, npcout=100, rdata1=10, rdata2=20, s_extendout=4, aluop=10, funct=100000, alusrc=1, regdst=1 → next edge: alu_result=14, zero=0, EX_MEM_NPC=116, five_bit_muxout=10, wb_ctlout=10, memwrite=1, branch=0, memread=0, rdata2out=20.
- Same but alusrc=0, regdst=0, s_extendout=8, aluop=01 → alu_result=32'hFFFFFFF6, zero=0, EX_MEM_NPC=132, five_bit_muxout=5.
- aluop=01, rdata1=rdata2=20, alusrc=0 → alu_result=0, zero=1.
- aluop=10, alusrc=0, rdata1=32'hFFFFFFFF, rdata2=1:
  - funct SLT → alu_result=1;
  - funct AND (rdata1=32'hF0F0, rdata2=32'hFF00) → 32'hF000;
  - funct OR → 32'hFFF0;
  - funct 000000 → alu_result=0, zero=1.
- Branch target wrap: npcout=32'hFFFFFFFC, s_extendout=32'h1 → EX_MEM_NPC=0; s_extendout=32'hFFFFFFFF (−1) with npcout=100 → 96.
